// File: rtl/mc_datapath.sv
// Multi-cycle MIPS datapath: FETCH/EXEC/MEM/WB sequencer with
// req/ack instruction and data memory ports.
module mc_datapath #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          LED_W     = 8,
    parameter logic [4:0]  LED_REG   = 5'd2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_ack,
    input  logic [31:0]      dmem_rdata,
    output logic [5:0]       op_c,
    output logic [5:0]       funct,
    output logic             zero,
    input  logic             argB_c,
    input  logic             we_c,
    input  logic             ext_c,
    input  logic             sh_d_c,
    input  logic             wd_c,
    input  logic             mem_rd_c,
    input  logic             mem_wr_c,
    input  logic [1:0]       dest_reg_c,
    input  logic [1:0]       result_c,
    input  logic [2:0]       pc_next_c,
    input  logic [3:0]       alu_c,
    output logic [1:0]       state,
    output logic             instr_done,
    output logic [LED_W-1:0] leds
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc, ir, aluout, shout, rt_q, mdr;
    logic [29:0] a_hi;
    logic        zero_q;
    logic [31:0] regs [32];

    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] a, b, rtv, ext_imm, alu, sh;
    logic [31:0] pc4, br_tgt, j_tgt, pc_nxt, wdat;
    logic [4:0]  dst;

    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign shamt   = ir[10:6];
    assign a       = regs[rs];
    assign rtv     = regs[rt];
    assign ext_imm = ext_c ? {{16{ir[15]}}, ir[15:0]} : {16'h0, ir[15:0]};
    assign b       = argB_c ? ext_imm : rtv;
    assign sh      = sh_d_c ? (rtv >> shamt) : (rtv << shamt);

    // ALU encoding: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sltu, 8 lui
    always_comb begin
        alu = '0;
        case (alu_c)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
            4'd2:    alu = a & b;
            4'd3:    alu = a | b;
            4'd4:    alu = a ^ b;
            4'd5:    alu = ~(a | b);
            4'd6:    alu = {31'h0, $signed(a) < $signed(b)};
            4'd7:    alu = {31'h0, a < b};
            4'd8:    alu = {b[15:0], 16'h0};
            default: alu = '0;
        endcase
    end

    assign pc4    = pc + 32'd4;
    assign br_tgt = pc4 + {{14{ir[15]}}, ir[15:0], 2'b00};
    assign j_tgt  = {pc[31:28], ir[25:0], 2'b00};

    always_comb begin
        pc_nxt = pc4;
        case (pc_next_c)
            3'd1:    pc_nxt = br_tgt;
            3'd2:    pc_nxt = j_tgt;
            3'd3:    pc_nxt = {a_hi, 2'b00};
            default: pc_nxt = pc4;
        endcase
    end

    always_comb begin
        dst  = 5'd0;
        wdat = aluout;
        case (dest_reg_c)
            2'd0:    dst = rd;
            2'd1:    dst = rt;
            2'd2:    dst = 5'd31;
            default: dst = 5'd0;
        endcase
        case (result_c)
            2'd1:    wdat = mdr;
            2'd2:    wdat = shout;
            default: wdat = aluout;
        endcase
        if (wd_c) wdat = pc4;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (imem_ack) state_d = S_EXEC;
            S_EXEC:  state_d = (mem_rd_c | mem_wr_c) ? S_MEM : S_WB;
            S_MEM:   if (dmem_ack) state_d = S_WB;
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= RESET_VEC;
            ir     <= '0;
            aluout <= '0;
            shout  <= '0;
            rt_q   <= '0;
            mdr    <= '0;
            a_hi   <= '0;
            zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: if (imem_ack) ir <= imem_rdata;
                S_EXEC: begin
                    a_hi   <= a[31:2];
                    aluout <= alu;
                    shout  <= sh;
                    rt_q   <= rtv;
                    zero_q <= (alu == '0);
                end
                S_MEM:   if (dmem_ack && !mem_wr_c) mdr <= dmem_rdata;
                S_WB:    pc <= pc_nxt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (state_q == S_WB && we_c && dst != 5'd0) begin
            regs[dst] <= wdat;
        end
    end

    // Requests are gated by reset so they fall the moment reset asserts
    assign imem_req   = reset && (state_q == S_FETCH);
    assign dmem_req   = reset && (state_q == S_MEM);
    assign dmem_we    = dmem_req && mem_wr_c;
    assign imem_addr  = pc;
    assign dmem_addr  = aluout;
    assign dmem_wdata = rt_q;
    assign op_c       = ir[31:26];
    assign funct      = ir[5:0];
    assign zero       = (state_q == S_EXEC) ? (alu == '0) : zero_q;
    assign state      = state_q;
    assign instr_done = (state_q == S_WB);
    assign leds       = regs[LED_REG][LED_W-1:0];

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: acts as decoder and memories, and checks
// every cycle against an instruction-level model.
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [5:0]  op_c, funct;
    logic        zero;
    logic        argB_c, we_c, ext_c, sh_d_c, wd_c, mem_rd_c, mem_wr_c;
    logic [1:0]  dest_reg_c, result_c;
    logic [2:0]  pc_next_c;
    logic [3:0]  alu_c;
    logic [1:0]  state;
    logic        instr_done;
    logic [7:0]  leds;

    always #5 clk = ~clk;

    mc_datapath dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .op_c(op_c), .funct(funct), .zero(zero),
        .argB_c(argB_c), .we_c(we_c), .ext_c(ext_c),
        .sh_d_c(sh_d_c), .wd_c(wd_c),
        .mem_rd_c(mem_rd_c), .mem_wr_c(mem_wr_c),
        .dest_reg_c(dest_reg_c), .result_c(result_c),
        .pc_next_c(pc_next_c), .alu_c(alu_c),
        .state(state), .instr_done(instr_done), .leds(leds)
    );

    // External control decoder (ALU: 0 add, 1 sub, 3 or)
    always_comb begin
        argB_c = 0; we_c = 0; ext_c = 0; sh_d_c = 0; wd_c = 0;
        mem_rd_c = 0; mem_wr_c = 0; dest_reg_c = 2'd0;
        result_c = 2'd0; pc_next_c = 3'd0; alu_c = 4'd0;
        case (op_c)
            6'd0: case (funct)
                6'd32:   we_c = 1;
                6'd0:    begin we_c = 1; result_c = 2'd2; end
                6'd8:    pc_next_c = 3'd3;
                default: ;
            endcase
            6'd8:  begin argB_c = 1; ext_c = 1; we_c = 1; dest_reg_c = 2'd1; end
            6'd13: begin argB_c = 1; we_c = 1; dest_reg_c = 2'd1; alu_c = 4'd3; end
            6'd35: begin
                argB_c = 1; ext_c = 1; we_c = 1; dest_reg_c = 2'd1;
                result_c = 2'd1; mem_rd_c = 1;
            end
            6'd43: begin argB_c = 1; ext_c = 1; mem_wr_c = 1; end
            6'd4:  begin alu_c = 4'd1; pc_next_c = zero ? 3'd1 : 3'd0; end
            6'd5:  begin alu_c = 4'd1; pc_next_c = zero ? 3'd0 : 3'd1; end
            6'd2:  pc_next_c = 3'd2;
            6'd3:  begin pc_next_c = 3'd2; we_c = 1; dest_reg_c = 2'd2; wd_c = 1; end
            default: ;
        endcase
    end

    int          n_chk = 0, n_fail = 0;
    int          ph = 0, dreq_cnt = 0, wr_cnt = 0;
    bit          chk_en = 0;
    logic [31:0] mpc;
    logic [31:0] mreg [32];
    bit          e_mem, e_we, e_zchk, e_zero, w_en;
    logic [31:0] e_addr, e_wdata, n_pc, w_val;
    logic [4:0]  w_idx;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Instruction-level semantics from the ISA fields
    task automatic predict(input logic [31:0] ins, input logic [31:0] ld);
        logic [31:0] s, t, simm, zimm;
        s = mreg[ins[25:21]];
        t = mreg[ins[20:16]];
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'h0, ins[15:0]};
        e_mem = 0; e_we = 0; e_zchk = 0; e_zero = 0; w_en = 0;
        e_addr = 0; e_wdata = 0; n_pc = mpc + 4; w_val = 0; w_idx = 0;
        case (ins[31:26])
            6'd0: case (ins[5:0])
                6'd32: begin w_en = 1; w_idx = ins[15:11]; w_val = s + t; end
                6'd0:  begin w_en = 1; w_idx = ins[15:11]; w_val = t << ins[10:6]; end
                6'd8:  n_pc = s & ~32'h3;
                default: ;
            endcase
            6'd8:  begin w_en = 1; w_idx = ins[20:16]; w_val = s + simm; end
            6'd13: begin w_en = 1; w_idx = ins[20:16]; w_val = s | zimm; end
            6'd35: begin
                e_mem = 1; e_addr = s + simm;
                w_en = 1; w_idx = ins[20:16]; w_val = ld;
            end
            6'd43: begin e_mem = 1; e_we = 1; e_addr = s + simm; e_wdata = t; end
            6'd4, 6'd5: begin
                e_zchk = 1; e_zero = (s == t);
                if ((s == t) == (ins[31:26] == 6'd4))
                    n_pc = mpc + 4 + (simm << 2);
            end
            6'd2:  n_pc = {mpc[31:28], ins[25:0], 2'b00};
            6'd3:  begin
                n_pc = {mpc[31:28], ins[25:0], 2'b00};
                w_en = 1; w_idx = 5'd31; w_val = mpc + 4;
            end
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] ins, input int wi, input int wd,
                       input logic [31:0] ld);
        predict(ins, ld);
        for (int k = 0; k <= wi; k++) begin
            ph = 0; imem_ack = (k == wi);
            imem_rdata = (k == wi) ? ins : 32'hFFFF_FFFF;
            step();
        end
        ph = 1; imem_ack = 1; imem_rdata = 32'hFFFF_FFFF; dmem_ack = 1;
        step();
        imem_ack = 0; dmem_ack = 0;
        if (e_mem) begin
            for (int k = 0; k <= wd; k++) begin
                ph = 2; dmem_ack = (k == wd);
                dmem_rdata = (k == wd) ? ld : 32'h0BAD_0BAD;
                step();
            end
            dmem_ack = 0;
        end
        ph = 3; imem_ack = 1;
        step();
        imem_ack = 0;
        mpc = n_pc;
        if (w_en && w_idx != 5'd0) mreg[w_idx] = w_val;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", 32'(state), 32'(ph));
            chk("imem_req", 32'(imem_req), 32'(ph == 0));
            if (ph == 0) chk("imem_addr", imem_addr, mpc);
            chk("dmem_req", 32'(dmem_req), 32'(ph == 2));
            if (ph == 2) begin
                chk("dmem_we", 32'(dmem_we), 32'(e_we));
                chk("dmem_addr", dmem_addr, e_addr);
                if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
            end
            if (ph == 1 && e_zchk) chk("zero", 32'(zero), 32'(e_zero));
            chk("instr_done", 32'(instr_done), 32'(ph == 3));
            chk("leds", 32'(leds), 32'(mreg[2][7:0]));
            if (dmem_req) dreq_cnt++;
        end
    end

    always @(posedge clk)
        if (dmem_req && dmem_we && dmem_ack) wr_cnt++;

    initial begin
        reset = 0; imem_ack = 0; imem_rdata = 0; dmem_ack = 0; dmem_rdata = 0;
        mpc = 32'h0;
        for (int i = 0; i < 32; i++) mreg[i] = 0;
        repeat (2) step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_done", 32'(instr_done), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_pc", imem_addr, 32'h0);
        reset = 1; chk_en = 1;

        run(32'h2002_0005, 0, 0, 0);
        chk("addi_leds", 32'(leds), 32'h05);
        chk("addi_pc", mpc, 32'h4);
        dreq_cnt = 0;
        run(32'h8C43_0000, 0, 3, 32'hDEAD_BEEF);
        chk("lw_req_cycles", 32'(dreq_cnt), 32'd4);
        chk("lw_r3", mreg[3], 32'hDEAD_BEEF);
        run(32'h1000_FFFF, 1, 0, 0);
        chk("beq_pc", mpc, 32'h8);
        run(32'h1400_0005, 2, 0, 0);
        chk("bne_pc", mpc, 32'hC);
        run(32'h0800_0004, 0, 0, 0);
        chk("j_pc", mpc, 32'h10);
        run(32'h0C00_0040, 1, 0, 0);
        chk("jal_r31", mreg[31], 32'h14);
        chk("jal_pc", mpc, 32'h100);
        run(32'h03E0_0008, 0, 0, 0);
        chk("jr31_pc", mpc, 32'h14);
        run(32'h2004_0017, 0, 0, 0);
        run(32'h0080_0008, 0, 0, 0);
        chk("jr_unaligned_pc", mpc, 32'h14);
        run(32'h3400_FFFF, 1, 0, 0);
        run(32'h0000_1020, 0, 0, 0);
        chk("r0_reads_zero", 32'(leds), 32'h00);
        run(32'hAC83_0008, 0, 1, 0);
        chk("sw_writes", 32'(wr_cnt), 32'd1);
        run(32'h0003_1100, 0, 0, 0);
        chk("sll_leds", 32'(leds), 32'hF0);
        run(32'h2005_FFFC, 0, 0, 0);
        run(32'h00A0_0008, 0, 0, 0);
        chk("jr_top_pc", mpc, 32'hFFFF_FFFC);
        run(32'h0085_1020, 1, 0, 0);
        chk("wrap_leds", 32'(leds), 32'h13);
        chk("wrap_pc", mpc, 32'h0);

        // Store abandoned by reset while waiting in MEM
        predict(32'hAC02_0000, 0);
        ph = 0; imem_ack = 1; imem_rdata = 32'hAC02_0000; step();
        imem_ack = 0; ph = 1; step();
        ph = 2; dmem_ack = 0; step();
        chk_en = 0; reset = 0; dmem_ack = 1;
        #1;
        chk("midmem_dmem_req", 32'(dmem_req), 32'd0);
        chk("midmem_imem_req", 32'(imem_req), 32'd0);
        chk("midmem_state", 32'(state), 32'd0);
        chk("midmem_leds", 32'(leds), 32'd0);
        step(); step();
        chk("midmem_no_write", 32'(wr_cnt), 32'd1);
        chk("midmem_pc", imem_addr, 32'h0);
        mpc = 32'h0;
        for (int i = 0; i < 32; i++) mreg[i] = 0;
        dmem_ack = 0; reset = 1; chk_en = 1; ph = 0;
        run(32'h2042_0007, 0, 0, 0);
        chk("restart_leds", 32'(leds), 32'h07);
        chk("restart_pc", mpc, 32'h4);
        chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
